// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package seq_divider_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iteration counter must hold the full count WIDTH down to zero.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake, operand and result bundle for seq_divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = seq_divider_pkg::DEF_WIDTH
);

  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH:0]   rem_nxt_c,
  output logic             q_bit_c
);

  logic [WIDTH+1:0] shifted_c;
  logic [WIDTH+1:0] diff_c;

  always_comb begin
    shifted_c = {rem, dbit};
    diff_c    = shifted_c - (WIDTH+2)'(dmag);
    q_bit_c   = (shifted_c >= (WIDTH+2)'(dmag));
    rem_nxt_c = q_bit_c ? (WIDTH+1)'(diff_c) : (WIDTH+1)'(shifted_c);
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, radix-2 restoring.
// Optional SEQ_DIVIDER_FAST_EXC_EN resolves divide-by-zero and high-half overflow at start.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic        clk,
  input logic        rst_n,
  seq_divider_if.slave bus
);

  localparam int unsigned CW = cnt_w(WIDTH);
  localparam int unsigned DW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] QPOS_MAX = WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic [WIDTH:0]   QNEG_MAX = (WIDTH+1)'(1 << (WIDTH - 1));

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] dmag;
  logic             rsign, dsign, dzero, hi_ovf;

  logic [DW-1:0]    dd_mag_c;
  logic [WIDTH-1:0] dv_mag_c;
  logic             accept_c, fast_exc_c, ovf_c;
  logic [WIDTH:0]   step_rem_c;
  logic             step_q_c;

  // Operand magnitudes; the most negative values map to their unsigned magnitude.
  assign dd_mag_c = bus.dividend[DW-1] ? (~bus.dividend + DW'(1)) : bus.dividend;
  assign dv_mag_c = bus.divisor[WIDTH-1] ? (~bus.divisor + WIDTH'(1)) : bus.divisor;
  assign accept_c = bus.start && ((state == IDLE) || (state == DONE));

`ifdef SEQ_DIVIDER_FAST_EXC_EN
  assign fast_exc_c = (dv_mag_c == '0) || (dd_mag_c[DW-1:WIDTH] >= dv_mag_c);
`else
  assign fast_exc_c = 1'b0;
`endif

  assign ovf_c = hi_ovf
               | (~rsign & (qreg > QPOS_MAX))
               | (rsign & ({1'b0, qreg} > QNEG_MAX));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem),
    .dbit      (qreg[WIDTH-1]),
    .dmag      (dmag),
    .rem_nxt_c (step_rem_c),
    .q_bit_c   (step_q_c)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept_c) state_nxt = fast_exc_c ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept_c ? (fast_exc_c ? DONE : CALC) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus.busy <= (state_nxt == CALC) || (state_nxt == FIX);
      bus.done <= (state_nxt == DONE);
    end
  end

  // Working registers and result outputs; results only change at accept or FIX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt             <= '0;
      rem             <= '0;
      qreg            <= '0;
      dmag            <= '0;
      rsign           <= 1'b0;
      dsign           <= 1'b0;
      dzero           <= 1'b0;
      hi_ovf          <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else if (accept_c) begin
      cnt             <= CW'(WIDTH);
      rem             <= (WIDTH+1)'(dd_mag_c[DW-1:WIDTH]);
      qreg            <= dd_mag_c[WIDTH-1:0];
      dmag            <= dv_mag_c;
      rsign           <= bus.dividend[DW-1] ^ bus.divisor[WIDTH-1];
      dsign           <= bus.dividend[DW-1];
      dzero           <= (dv_mag_c == '0);
      hi_ovf          <= (dd_mag_c[DW-1:WIDTH] >= dv_mag_c);
      bus.div_by_zero <= fast_exc_c & (dv_mag_c == '0);
      bus.overflow    <= fast_exc_c & (dv_mag_c != '0);
      if (fast_exc_c) begin
        bus.quotient  <= '0;
        bus.remainder <= '0;
      end
    end else if ((state == CALC) && (cnt != '0)) begin
      rem  <= step_rem_c;
      qreg <= {qreg[WIDTH-2:0], step_q_c};
      cnt  <= cnt - CW'(1);
    end else if (state == FIX) begin
      if (dzero) begin
        bus.div_by_zero <= 1'b1;
        bus.overflow    <= 1'b0;
        bus.quotient    <= '0;
        bus.remainder   <= '0;
      end else if (ovf_c) begin
        bus.overflow    <= 1'b1;
        bus.quotient    <= '0;
        bus.remainder   <= '0;
      end else begin
        bus.quotient    <= rsign ? (~qreg + WIDTH'(1)) : qreg;
        bus.remainder   <= dsign ? (~rem[WIDTH-1:0] + WIDTH'(1)) : rem[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: integer reference model, randomized and directed operations.
module tb_seq_divider;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           acc;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;
  exp_t sb[$];

  seq_divider_if #(.WIDTH(W)) bus();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic exp_t model(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    exp_t e;
    int a, b, qi, ri, amag, bmag;
    a = int'($signed(dd));
    b = int'($signed(dv));
    amag = (a < 0) ? -a : a;
    bmag = (b < 0) ? -b : b;
    e.q = '0; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b0; e.acc = 0; e.lat = W + 2;
    if (b == 0) begin
      e.dbz = 1'b1;
`ifdef SEQ_DIVIDER_FAST_EXC_EN
      e.lat = 1;
`endif
    end else begin
      qi = a / b;
      ri = a % b;
      if (qi > (1 << (W - 1)) - 1 || qi < -(1 << (W - 1))) begin
        e.ovf = 1'b1;
`ifdef SEQ_DIVIDER_FAST_EXC_EN
        if (amag >= (bmag << W)) e.lat = 1;
`endif
      end else begin
        e.q = W'(qi);
        e.r = W'(ri);
      end
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", 32'(bus.quotient), 32'(e.q));
        chk("remainder", 32'(bus.remainder), 32'(e.r));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
        chk("overflow", 32'(bus.overflow), 32'(e.ovf));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Called at a negedge with busy=0; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    exp_t e;
    e = model(dd, dv);
    e.acc = cyc + 1;
    sb.push_back(e);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv, input int gap);
    issue(dd, dv);
    wait_done();
    repeat (gap) @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "_done"}, 32'(bus.done), 32'(0));
    chk({tag, "_quotient"}, 32'(bus.quotient), 32'(0));
    chk({tag, "_remainder"}, 32'(bus.remainder), 32'(0));
    chk({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'(0));
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, separated by an idle cycle.
    run_op(8'b00110001, 4'b1001, 1);   // 49 / -7
    run_op(8'b11001111, 4'b0111, 1);   // -49 / 7
    run_op(8'b00001110, 4'b0111, 1);   // 14 / 7
    run_op(8'b00001111, 4'b0100, 1);   // 15 / 4
    run_op(8'b11110001, 4'b0100, 1);   // -15 / 4
    run_op(8'b11110000, 4'b0010, 1);   // -16 / 2
    run_op(8'b01000000, 4'b0010, 1);   // 64 / 2 overflow
    run_op(8'b01011010, 4'b0000, 1);   // divide by zero
    run_op(8'b00001111, 4'b0001, 1);   // 15 / 1: overflow without high-half condition
    run_op(8'b10000000, 4'b1000, 1);   // -128 / -8

    // Back-to-back: second start issued in the DONE cycle.
    run_op(8'b00011000, 4'b0011, 0);
    run_op(8'b11101001, 4'b1101, 0);
    run_op(8'b00000000, 4'b0000, 0);
    run_op(8'b00010101, 4'b1110, 2);

    // Start pulsed while busy must be ignored.
    snap = done_seen;
    issue(8'b00110001, 4'b1001);
    bus.dividend = 8'b01000000;
    bus.divisor  = 4'b0000;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done();
    repeat (W + 4) @(negedge clk);
    chk("busy_start_ignored", 32'(done_seen - snap), 32'(1));

    // Reset during CALC abandons the operation.
    issue(8'b00001111, 4'b0100);
    rst_n = 1'b0;
    sb.delete();
    snap = done_seen;
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero_outputs("midreset");
    repeat (W + 4) @(negedge clk);
    chk("midreset_no_done", 32'(done_seen - snap), 32'(0));

    // Randomized operations, mostly in-range dividends with some full-range ones.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) dd = (2*W)'($urandom);
      else dd = (2*W)'(int'($urandom_range(0, 100)) - 50);
      dv = W'($urandom);
      run_op(dd, dv, int'($urandom_range(0, 2)));
    end

    repeat (W + 4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential signed divider; the inverse of the team's 4x4 signed Booth multiplier.
- Takes a 2*WIDTH-bit signed dividend (a product-width value) and a WIDTH-bit signed divisor.
- Produces a WIDTH-bit signed quotient and a WIDTH-bit signed remainder over a fixed multi-cycle radix-2 iteration, with a start/done handshake.
- Sits beside the multiplier in the arithmetic datapath; feeding it P and one factor returns the other factor.

Parameters:
WIDTH, 4, operand width; dividend is 2*WIDTH bits, quotient/remainder WIDTH bits.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  request; sampled when busy=0
dividend  in  2*WIDTH  signed two's-complement dividend
divisor  in  WIDTH  signed two's-complement divisor
busy  out  1  operation in progress
done  out  1  one-cycle pulse, results valid
quotient  out  WIDTH  signed quotient, truncated toward zero
remainder  out  WIDTH  signed remainder, sign follows dividend
div_by_zero  out  1  divisor was zero
overflow  out  1  true quotient not representable in WIDTH signed bits

Behaviour:
- Reset: rst_n=0 at a rising edge forces the following:
  - state IDLE; busy=0, done=0.
  - quotient, remainder, div_by_zero and overflow all 0.
  - Reset mid-operation abandons the operation with no done pulse.
- FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE: when start=1 at an edge:
  - Latch the magnitudes of dividend and divisor, plus the result sign (sign xor) and the dividend sign.
  - Clear the error flags; go to CALC.
- Start acceptance: start is accepted in IDLE and in DONE (back-to-back issue); it is ignored while busy=1.
- CALC: exactly WIDTH iterations, counted by a down-counter.
  - Each iteration does a shift-left of {rem, q} and a trial subtract of the divisor magnitude.
  - If the result is non-negative, commit it and shift a 1 into q; otherwise restore.
- FIX:
  - Negate q if the result sign is 1.
  - Negate rem if the dividend sign is 1.
  - Perform the error checks below; go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Go to IDLE, or to CALC if start=1.
- busy=1 in CALC and FIX only.
- Latency: start sampled at edge N gives done=1 during the cycle after edge N+WIDTH+2. This is fixed and independent of operand values.
- Outputs hold their values from DONE until the next accepted start or reset.
- Error checks:
  - Divisor zero: div_by_zero=1, quotient=0, remainder=0, overflow=0.
  - Overflow detection uses unsigned magnitudes:
    - high half of dividend magnitude >= divisor magnitude, or
    - positive result with magnitude > 2^(WIDTH-1)-1, or
    - negative result with magnitude > 2^(WIDTH-1).
  - On overflow: overflow=1, quotient=0, remainder=0.
- Arithmetic width rules:
  - Internal partial remainder is WIDTH+1 bits.
  - Dividend magnitude is 2*WIDTH bits unsigned; the most negative dividend magnitude is handled as an unsigned value.
  - Quotient -2^(WIDTH-1) is legal.

Optional Feature:
SEQ_DIVIDER_FAST_EXC_EN
- Defined: divide-by-zero and the high-half overflow condition are detected in IDLE at start acceptance.
  - The FSM goes straight to DONE, so done appears the cycle after the accepting edge.
  - Flags and zeroed results are as specified above.
- Undefined: all operations take the fixed WIDTH+2 latency.
- Normal-path latency is identical in both builds.

Decomposition:
- Package seq_divider_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - the default WIDTH constant;
  - the iteration-counter width function, clog2(WIDTH+1).
- One combinational sub-module div_step: one restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new remainder and quotient bit.
- The top instantiates div_step once and reuses it each CALC cycle.

Test Plan:
- 49/-7: dividend 8'b00110001, divisor 4'b1001 -> quotient 4'b1001, remainder 0, flags 0, done exactly WIDTH+2 cycles after start.
- -49/7 and 14/7: 8'b11001111 / 4'b0111 -> 4'b1001 rem 0; 8'b00001110 / 4'b0111 -> 4'b0010 rem 0.
- Remainder signs: 15/4 -> q 4'b0011 rem 4'b0011; -15/4 (8'b11110001) -> q 4'b1101 rem 4'b1101; -16/2 -> q 4'b1000 (legal edge).
- Errors: 64/2 -> overflow=1, q=0, r=0; any dividend / 4'b0000 -> div_by_zero=1, q=0. Both run with and without SEQ_DIVIDER_FAST_EXC_EN, checking latency of 1 vs WIDTH+2 cycles.
- Handshake: start pulsed while busy is ignored and the result is unchanged; start asserted in the DONE cycle produces a back-to-back second result; rst_n=0 mid-CALC gives no done pulse and all outputs 0.
